// File: rtl/meta_reg_pipe.sv
// meta_reg_pipe: a chain of N_STAGES register slices on a valid/ready metadata
// channel. MODE picks the slice type for every stage of the instance:
//   0 FULL  : primary + skid register, registered ready, 1 beat/clk
//   1 FWD   : single data/valid register, ready combinational through the chain
//   2 LIGHT : single register, registered ready, 1 beat every 2 clk
// The occ output counts the beats currently held, for drain checks.
// N_STAGES = 0 collapses the block to plain wires.
module meta_reg_pipe #(
    parameter int DATA_BITS = 32,
    parameter int N_STAGES  = 1,
    parameter int MODE      = 0
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic                                s_meta_valid,
    output logic                                s_meta_ready,
    input  logic [DATA_BITS-1:0]                s_meta_data,
    output logic                                m_meta_valid,
    input  logic                                m_meta_ready,
    output logic [DATA_BITS-1:0]                m_meta_data,
    output logic [$clog2(2*N_STAGES+2)-1:0]     occ
);

    localparam int OCC_BITS = $clog2(2*N_STAGES+2);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } full_state_t;

    // Refuse configurations outside the supported range at elaboration.
    if (N_STAGES < 0 || N_STAGES > 8) begin : g_bad_stages
        $error("meta_reg_pipe: N_STAGES must be in 0..8");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("meta_reg_pipe: MODE must be 0, 1 or 2");
    end
    if (DATA_BITS < 1) begin : g_bad_width
        $error("meta_reg_pipe: DATA_BITS must be at least 1");
    end

    if (N_STAGES == 0) begin : g_wires
        assign m_meta_valid = s_meta_valid;
        assign m_meta_data  = s_meta_data;
        assign s_meta_ready = m_meta_ready;
        assign occ          = '0;
    end else begin : g_pipe
        // Index 0 is the upstream port, index N_STAGES the downstream port;
        // stage gi consumes from index gi and produces into index gi+1.
        logic [N_STAGES:0]    stage_valid;
        logic [N_STAGES:0]    stage_ready;
        logic [DATA_BITS-1:0] stage_data [0:N_STAGES];
        logic [OCC_BITS-1:0]  occ_reg;
        logic                 top_in_fire;
        logic                 top_out_fire;

        assign stage_valid[0]        = s_meta_valid;
        assign stage_data[0]         = s_meta_data;
        assign s_meta_ready          = stage_ready[0];
        assign m_meta_valid          = stage_valid[N_STAGES];
        assign m_meta_data           = stage_data[N_STAGES];
        assign stage_ready[N_STAGES] = m_meta_ready;

        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
            // Only the register feeding m_meta carries a data reset.
            localparam bit IS_LAST = (gi == N_STAGES - 1);

            if (MODE == 0) begin : g_full
                full_state_t          state_reg;
                full_state_t          state_next;
                logic [DATA_BITS-1:0] prim_reg;
                logic [DATA_BITS-1:0] skid_reg;
                logic                 in_fire;
                logic                 out_fire;
                logic                 load_prim_in;
                logic                 load_prim_skid;
                logic                 load_skid;

                // Ready only depends on the skid being free, so no comb path
                // from downstream ready reaches upstream.
                assign stage_ready[gi]     = (state_reg != ST_TWO) && !areset;
                assign in_fire             = stage_valid[gi] && stage_ready[gi];
                assign out_fire            = (state_reg != ST_EMPTY) && stage_ready[gi+1];
                assign stage_valid[gi+1]   = (state_reg != ST_EMPTY);
                assign stage_data[gi+1]    = prim_reg;

                // Occupancy state register.
                always_ff @(posedge aclk) begin
                    if (areset) begin
                        state_reg <= ST_EMPTY;
                    end else begin
                        state_reg <= state_next;
                    end
                end

                // Next occupancy and which register loads from where.
                always_comb begin
                    state_next     = state_reg;
                    load_prim_in   = 1'b0;
                    load_prim_skid = 1'b0;
                    load_skid      = 1'b0;
                    case (state_reg)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state_next   = ST_ONE;
                                load_prim_in = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                load_prim_in = 1'b1;
                            end else if (in_fire) begin
                                state_next = ST_TWO;
                                load_skid  = 1'b1;
                            end else if (out_fire) begin
                                state_next = ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (out_fire) begin
                                state_next     = ST_ONE;
                                load_prim_skid = 1'b1;
                            end
                        end
                        default: state_next = ST_EMPTY;
                    endcase
                end

                // Payload registers: primary is the stage output, skid parks
                // the beat that arrived while the primary was stalled.
                always_ff @(posedge aclk) begin
                    if (areset && IS_LAST) begin
                        prim_reg <= '0;
                    end else if (load_prim_in) begin
                        prim_reg <= stage_data[gi];
                    end else if (load_prim_skid) begin
                        prim_reg <= skid_reg;
                    end
                    if (load_skid) begin
                        skid_reg <= stage_data[gi];
                    end
                end
            end else if (MODE == 1) begin : g_fwd
                logic                 valid_reg;
                logic [DATA_BITS-1:0] data_reg;
                logic                 in_fire;

                // Ready passes straight through when the register drains
                // this cycle, so a full stage can refill on the same edge.
                assign stage_ready[gi]   = (!valid_reg || stage_ready[gi+1]) && !areset;
                assign in_fire           = stage_valid[gi] && stage_ready[gi];
                assign stage_valid[gi+1] = valid_reg;
                assign stage_data[gi+1]  = data_reg;

                // Valid follows upstream valid whenever the stage may advance.
                always_ff @(posedge aclk) begin
                    if (areset) begin
                        valid_reg <= 1'b0;
                    end else if (stage_ready[gi]) begin
                        valid_reg <= stage_valid[gi];
                    end
                end

                // Payload captured on every accepted beat.
                always_ff @(posedge aclk) begin
                    if (areset && IS_LAST) begin
                        data_reg <= '0;
                    end else if (in_fire) begin
                        data_reg <= stage_data[gi];
                    end
                end
            end else begin : g_light
                logic                 valid_reg;
                logic [DATA_BITS-1:0] data_reg;
                logic                 in_fire;

                // Accept only when empty: accept and emit alternate.
                assign stage_ready[gi]   = !valid_reg && !areset;
                assign in_fire           = stage_valid[gi] && stage_ready[gi];
                assign stage_valid[gi+1] = valid_reg;
                assign stage_data[gi+1]  = data_reg;

                // Fill on accept, empty once downstream takes the beat.
                always_ff @(posedge aclk) begin
                    if (areset) begin
                        valid_reg <= 1'b0;
                    end else if (in_fire) begin
                        valid_reg <= 1'b1;
                    end else if (valid_reg && stage_ready[gi+1]) begin
                        valid_reg <= 1'b0;
                    end
                end

                // Payload captured on every accepted beat.
                always_ff @(posedge aclk) begin
                    if (areset && IS_LAST) begin
                        data_reg <= '0;
                    end else if (in_fire) begin
                        data_reg <= stage_data[gi];
                    end
                end
            end
        end

        // Hand-offs between stages conserve beats, so the total held equals
        // beats accepted upstream minus beats delivered downstream.
        assign top_in_fire  = s_meta_valid && stage_ready[0];
        assign top_out_fire = stage_valid[N_STAGES] && m_meta_ready;

        // Occupancy counter, updated on the same edge as the transfers.
        always_ff @(posedge aclk) begin
            if (areset) begin
                occ_reg <= '0;
            end else begin
                occ_reg <= occ_reg + OCC_BITS'(top_in_fire) - OCC_BITS'(top_out_fire);
            end
        end

        assign occ = occ_reg;
    end

endmodule

// File: tb/tb_meta_reg_pipe.sv
// Testbench for meta_reg_pipe: several instances with different mode, depth
// and width share one clock and reset; each scenario task drives one of them
// and compares against expectations computed here (sequence counters,
// queues of accepted beats, occupancy bounds).
module tb_meta_reg_pipe;

    localparam int NI   = 11;
    localparam int WMAX = 544;

    typedef logic [WMAX-1:0] wide_t;
    typedef struct {
        wide_t d;
        int    cyc;
    } beat_t;

    function automatic int cfg_mode(input int i);
        case (i)
            0, 1, 4, 5, 8: return 0;
            2, 6, 10:      return 1;
            default:       return 2;
        endcase
    endfunction

    function automatic int cfg_n(input int i);
        case (i)
            0: return 2;  1: return 3;  2: return 1;  3: return 1;
            4: return 0;  5: return 2;  6: return 3;  7: return 2;
            8: return 4;  9: return 3;  default: return 2;
        endcase
    endfunction

    function automatic int cfg_w(input int i);
        case (i)
            0: return 13;  1: return 96;  2: return 32;  3: return 6;
            4: return 544; 5: return 6;   6: return 11;  7: return 56;
            8: return 544; 9: return 11;  default: return 6;
        endcase
    endfunction

    function automatic int cfg_bound(input int i);
        if (cfg_n(i) == 0) return 0;
        if (cfg_mode(i) == 0) return 2 * cfg_n(i);
        return cfg_n(i);
    endfunction

    function automatic wide_t mask_w(input int w);
        wide_t m;
        m = '0;
        for (int k = 0; k < w; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic wide_t rand_wide();
        wide_t r;
        for (int k = 0; k < WMAX / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    logic      clk = 1'b0;
    logic      areset = 1'b1;
    logic      s_valid [NI];
    logic      s_ready [NI];
    logic      m_valid [NI];
    logic      m_ready [NI];
    wide_t     s_data  [NI];
    wide_t     m_data  [NI];
    logic [7:0] occ    [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W  = cfg_w(gi);
        localparam int N  = cfg_n(gi);
        localparam int OW = $clog2(2*N+2);
        logic [W-1:0]  s_d;
        logic [W-1:0]  m_d;
        logic [OW-1:0] occ_w;

        assign s_d        = s_data[gi][W-1:0];
        assign m_data[gi] = WMAX'(m_d);
        assign occ[gi]    = 8'(occ_w);

        meta_reg_pipe #(
            .DATA_BITS(W),
            .N_STAGES (N),
            .MODE     (cfg_mode(gi))
        ) u_dut (
            .aclk        (clk),
            .areset      (areset),
            .s_meta_valid(s_valid[gi]),
            .s_meta_ready(s_ready[gi]),
            .s_meta_data (s_d),
            .m_meta_valid(m_valid[gi]),
            .m_meta_ready(m_ready[gi]),
            .m_meta_data (m_d),
            .occ         (occ_w)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs to one instance and let combinational paths settle.
    task automatic drive(input int idx, input logic v, input wide_t d, input logic r);
        s_valid[idx] = v;
        s_data[idx]  = d & mask_w(cfg_w(idx));
        m_ready[idx] = r;
        #1;
    endtask

    task automatic reset_all();
        areset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            s_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
            s_data[i]  = '0;
        end
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            s_valid[i] = 1'b1;
            s_data[i]  = rand_wide() & mask_w(cfg_w(i));
            m_ready[i] = 1'b1;
        end
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            if (cfg_n(i) > 0) begin
                if (cfg_mode(i) != 1) begin
                    n_checks++;
                    if (s_ready[i] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL reset_ready idx=%0d got=%b exp=0", i, s_ready[i]);
                    end
                end
                n_checks++;
                if (m_valid[i] !== 1'b0 || m_data[i] !== '0 || occ[i] !== 8'd0) begin
                    n_fail++;
                    $display("FAIL reset_out idx=%0d got valid=%b data=%h occ=%0d exp 0/0/0",
                             i, m_valid[i], m_data[i], occ[i]);
                end
            end
        end
        areset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            s_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            if (cfg_n(i) > 0) begin
                n_checks++;
                if (s_ready[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_after_reset idx=%0d got=%b exp=1", i, s_ready[i]);
                end
            end
        end
        tick();
    endtask

    // FULL N=2: 100 back-to-back beats with downstream always ready.
    task automatic test_full_stream();
        int sent, got, cyc, first_acc, last_acc, first_out, last_out;
        bit inf, outf;
        wide_t od;
        sent = 0; got = 0; cyc = 0;
        first_acc = -1; last_acc = -1; first_out = -1; last_out = -1;
        while (got < 100 && cyc < 300) begin
            drive(0, sent < 100, wide_t'(sent + 1), 1'b1);
            inf  = s_valid[0] && s_ready[0];
            outf = m_valid[0] && m_ready[0];
            od   = m_data[0];
            if (inf) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end
            if (outf) begin
                n_checks++;
                if (od !== wide_t'(got + 1)) begin
                    n_fail++;
                    $display("FAIL stream_data beat=%0d got=%h exp=%h", got, od, got + 1);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            tick();
            cyc++;
            n_checks++;
            if (occ[0] > 8'd2) begin
                n_fail++;
                $display("FAIL stream_occ cyc=%0d got=%0d exp<=2", cyc, occ[0]);
            end
        end
        n_checks++;
        if (got != 100) begin
            n_fail++;
            $display("FAIL stream_count got=%0d exp=100", got);
        end
        n_checks++;
        if (first_out - first_acc != 2) begin
            n_fail++;
            $display("FAIL stream_latency got=%0d exp=2", first_out - first_acc);
        end
        n_checks++;
        if (last_out - first_out != 99 || last_acc - first_acc != 99) begin
            n_fail++;
            $display("FAIL stream_rate out_span=%0d in_span=%0d exp=99/99",
                     last_out - first_out, last_acc - first_acc);
        end
    endtask

    // FULL N=3: downstream stalled, exactly two beats per stage fit.
    task automatic test_full_stall();
        wide_t beats [8];
        int sent, got;
        wide_t od;
        for (int k = 0; k < 8; k++) beats[k] = rand_wide() & mask_w(96);
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1, sent < 8, (sent < 8) ? beats[sent] : '0, 1'b0);
            if (s_valid[1] && s_ready[1]) sent++;
            tick();
        end
        drive(1, sent < 8, (sent < 8) ? beats[sent] : '0, 1'b0);
        n_checks++;
        if (sent != 6) begin
            n_fail++;
            $display("FAIL stall_accepted got=%0d exp=6", sent);
        end
        n_checks++;
        if (s_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready got=%b exp=0", s_ready[1]);
        end
        n_checks++;
        if (occ[1] !== 8'd6) begin
            n_fail++;
            $display("FAIL stall_occ got=%0d exp=6", occ[1]);
        end
        for (int c = 0; c < 60 && got < 8; c++) begin
            drive(1, sent < 8, (sent < 8) ? beats[sent] : '0, 1'b1);
            od = m_data[1];
            if (m_valid[1] && m_ready[1]) begin
                n_checks++;
                if (od !== beats[got]) begin
                    n_fail++;
                    $display("FAIL stall_data beat=%0d got=%h exp=%h", got, od, beats[got]);
                end
                got++;
            end
            if (s_valid[1] && s_ready[1]) sent++;
            tick();
        end
        drive(1, 1'b0, '0, 1'b0);
        n_checks++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL stall_drain got=%0d exp=8", got);
        end
    endtask

    // FWD N=1: downstream ready toggles every cycle.
    task automatic test_fwd_toggle();
        wide_t q [$];
        wide_t pend, od, expd;
        logic r;
        pend = rand_wide() & mask_w(32);
        for (int c = 0; c < 60; c++) begin
            r = (c < 40) ? ((c % 2) == 0) : 1'b1;
            drive(2, c < 40, pend, r);
            od = m_data[2];
            if (m_valid[2]) begin
                n_checks++;
                if (s_ready[2] !== r) begin
                    n_fail++;
                    $display("FAIL fwd_ready_track cyc=%0d got=%b exp=%b", c, s_ready[2], r);
                end
            end
            if (s_valid[2] && s_ready[2]) begin
                q.push_back(pend);
                pend = rand_wide() & mask_w(32);
            end
            if (m_valid[2] && m_ready[2]) begin
                n_checks++;
                expd = (q.size() > 0) ? q[0] : '0;
                if (q.size() == 0 || od !== expd) begin
                    n_fail++;
                    $display("FAIL fwd_data cyc=%0d got=%h exp=%h", c, od, expd);
                end
                if (q.size() > 0) void'(q.pop_front());
            end
            tick();
            n_checks++;
            if (occ[2] > 8'd1) begin
                n_fail++;
                $display("FAIL fwd_occ cyc=%0d got=%0d exp<=1", c, occ[2]);
            end
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL fwd_no_loss got=%0d exp=0 beats left", q.size());
        end
        drive(2, 1'b0, '0, 1'b0);
    endtask

    // LIGHT N=1: continuous traffic yields one beat every two cycles.
    task automatic test_light_rate();
        wide_t q [$];
        wide_t pend, od, expd;
        int ins, outs, both;
        bit inf, outf;
        ins = 0; outs = 0; both = 0;
        pend = rand_wide() & mask_w(6);
        for (int c = 0; c < 100; c++) begin
            drive(3, 1'b1, pend, 1'b1);
            inf  = s_valid[3] && s_ready[3];
            outf = m_valid[3] && m_ready[3];
            od   = m_data[3];
            if (inf && outf) both++;
            if (inf) begin
                q.push_back(pend);
                pend = rand_wide() & mask_w(6);
                ins++;
            end
            if (outf) begin
                n_checks++;
                expd = (q.size() > 0) ? q[0] : '0;
                if (q.size() == 0 || od !== expd) begin
                    n_fail++;
                    $display("FAIL light_data cyc=%0d got=%h exp=%h", c, od, expd);
                end
                if (q.size() > 0) void'(q.pop_front());
                outs++;
            end
            tick();
        end
        n_checks++;
        if (outs != 50 || ins != 50) begin
            n_fail++;
            $display("FAIL light_rate got in=%0d out=%0d exp 50/50", ins, outs);
        end
        n_checks++;
        if (both != 0) begin
            n_fail++;
            $display("FAIL light_alternate got=%0d overlapping cycles exp=0", both);
        end
        drive(3, 1'b0, '0, 1'b1);
        tick();
        tick();
    endtask

    // FULL N=2: reset while four beats are held, then a fresh beat.
    task automatic test_reset_midflight();
        int sent, outs, out_cyc;
        wide_t out_d;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, sent < 4, wide_t'(sent + 16), 1'b0);
            if (s_valid[0] && s_ready[0]) sent++;
            tick();
        end
        n_checks++;
        if (sent != 4) begin
            n_fail++;
            $display("FAIL mid_fill got=%0d exp=4", sent);
        end
        areset = 1'b1;
        drive(0, 1'b1, wide_t'(32'h77), 1'b0);
        n_checks++;
        if (s_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready got=%b exp=0", s_ready[0]);
        end
        tick();
        n_checks++;
        if (m_valid[0] !== 1'b0 || m_data[0] !== '0 || occ[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear got valid=%b data=%h occ=%0d exp 0/0/0",
                     m_valid[0], m_data[0], occ[0]);
        end
        areset = 1'b0;
        drive(0, 1'b1, wide_t'(32'hA5), 1'b1);
        n_checks++;
        if (s_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ready_after got=%b exp=1", s_ready[0]);
        end
        tick();
        outs = 0; out_cyc = -1; out_d = '0;
        for (int c = 1; c < 10; c++) begin
            drive(0, 1'b0, '0, 1'b1);
            if (m_valid[0] && m_ready[0]) begin
                if (outs == 0) begin
                    out_cyc = c;
                    out_d   = m_data[0];
                end
                outs++;
            end
            tick();
        end
        n_checks++;
        if (outs != 1 || out_cyc != 2 || out_d !== wide_t'(32'hA5)) begin
            n_fail++;
            $display("FAIL mid_new_beat got count=%0d edge=%0d data=%h exp 1/2/a5",
                     outs, out_cyc, out_d);
        end
    endtask

    // N=0: output must mirror input combinationally.
    task automatic test_wires();
        logic v, r;
        wide_t d;
        for (int c = 0; c < 1000; c++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = rand_wide();
            drive(4, v, d, r);
            n_checks++;
            if (m_valid[4] !== v || m_data[4] !== d || s_ready[4] !== r || occ[4] !== 8'd0) begin
                n_fail++;
                $display("FAIL wires cyc=%0d got v=%b r=%b occ=%0d data=%h exp v=%b r=%b occ=0 data=%h",
                         c, m_valid[4], s_ready[4], occ[4], m_data[4], v, r, d);
            end
            tick();
        end
        drive(4, 1'b0, '0, 1'b0);
    endtask

    // Random traffic and backpressure on one instance with a beat scoreboard.
    task automatic test_random(input int idx);
        beat_t q [$];
        beat_t b;
        wide_t pend, od;
        logic pend_v, r, prev_stall;
        wide_t prev_d;
        bit inf, outf;
        int cyc, n, bound, w;
        n = cfg_n(idx); bound = cfg_bound(idx); w = cfg_w(idx);
        reset_all();
        pend_v = 1'b0; pend = '0; prev_stall = 1'b0; prev_d = '0; cyc = 0;
        while (cyc < 300 || ((q.size() != 0 || pend_v) && cyc < 600)) begin
            if (!pend_v && cyc < 300 && $urandom_range(0, 99) < 70) begin
                pend_v = 1'b1;
                pend   = rand_wide() & mask_w(w);
            end
            r = (cyc >= 300) ? 1'b1 : 1'($urandom_range(0, 99) < 60);
            drive(idx, pend_v, pend, r);
            if (prev_stall) begin
                n_checks++;
                if (m_valid[idx] !== 1'b1 || m_data[idx] !== prev_d) begin
                    n_fail++;
                    $display("FAIL rand_hold idx=%0d cyc=%0d got v=%b d=%h exp v=1 d=%h",
                             idx, cyc, m_valid[idx], m_data[idx], prev_d);
                end
            end
            if (n > 0 && q.size() == bound) begin
                n_checks++;
                if (s_ready[idx] !== ((cfg_mode(idx) == 1) ? r : 1'b0)) begin
                    n_fail++;
                    $display("FAIL rand_full_ready idx=%0d cyc=%0d got=%b exp=%b", idx, cyc,
                             s_ready[idx], (cfg_mode(idx) == 1) ? r : 1'b0);
                end
            end
            inf  = s_valid[idx] && s_ready[idx];
            outf = m_valid[idx] && m_ready[idx];
            od   = m_data[idx];
            if (inf) begin
                b.d = pend; b.cyc = cyc;
                q.push_back(b);
            end
            if (outf) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_data idx=%0d cyc=%0d got=%h exp=<no beat>", idx, cyc, od);
                end else begin
                    if (od !== q[0].d || cyc - q[0].cyc < n) begin
                        n_fail++;
                        $display("FAIL rand_data idx=%0d cyc=%0d got=%h lat=%0d exp=%h lat>=%0d",
                                 idx, cyc, od, cyc - q[0].cyc, q[0].d, n);
                    end
                    void'(q.pop_front());
                end
            end
            prev_stall = m_valid[idx] && !r;
            prev_d     = od;
            tick();
            cyc++;
            if (inf) pend_v = 1'b0;
            n_checks++;
            if (occ[idx] !== 8'(q.size()) || q.size() > bound) begin
                n_fail++;
                $display("FAIL rand_occ idx=%0d cyc=%0d got=%0d exp=%0d bound=%0d",
                         idx, cyc, occ[idx], q.size(), bound);
            end
        end
        n_checks++;
        if (q.size() != 0 || pend_v) begin
            n_fail++;
            $display("FAIL rand_drain idx=%0d got=%0d beats left exp=0", idx, q.size());
        end
        drive(idx, 1'b0, '0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            s_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
            s_data[i]  = '0;
        end
        tick();
        test_reset();
        test_full_stream();
        test_full_stall();
        test_fwd_toggle();
        test_light_rate();
        test_reset_midflight();
        test_wires();
        for (int i = 0; i < NI; i++) test_random(i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit");
    end

endmodule
